// File: rtl/cmplx_ram_pkg.sv
// cmplx_ram_pkg: shared widths, complex word type and bit-reverse helper for the ping-pong RAM
package cmplx_ram_pkg;
  localparam int DEF_DW = 32;
  localparam int DEF_AW = 10;
  typedef struct packed {
    logic [DEF_DW-1:0] re;
    logic [DEF_DW-1:0] im;
  } cplx_t;
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int w);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++)
      if (i < w) r[i] = v[w-1-i];
    return r;
  endfunction
endpackage

// File: rtl/cmplx_bank.sv
// cmplx_bank: one true dual-port complex bank, registered reads, port B wins same-address collisions
module cmplx_bank
  import cmplx_ram_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we_a,
  input  logic [AW-1:0]   addr_a,
  input  logic [2*DW-1:0] d_a,
  output logic [2*DW-1:0] q_a,
  input  logic            we_b,
  input  logic [AW-1:0]   addr_b,
  input  logic [2*DW-1:0] d_b,
  output logic [2*DW-1:0] q_b
);
  logic [2*DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= d_a;
    if (we_b) mem[addr_b] <= d_b;
  end
  always_ff @(posedge clk)
    if (rst) begin
      q_a <= '0;
      q_b <= '0;
    end else begin
      q_a <= mem[addr_a];
      q_b <= mem[addr_b];
    end
endmodule

// File: rtl/cmplx_pingpong_ram.sv
// cmplx_pingpong_ram: two-bank stream/engine complex RAM; define CMPLX_BITREV_EN for bit-reversed fill order
module cmplx_pingpong_ram
  import cmplx_ram_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_real,
  input  logic [DW-1:0] in_img,
  output logic          overrun,
  output logic          frame_ready,
  input  logic          eng_done,
  input  logic [AW-1:0] address_a,
  input  logic [AW-1:0] address_b,
  input  logic [DW-1:0] dreal_a,
  input  logic [DW-1:0] dimg_a,
  input  logic [DW-1:0] dreal_b,
  input  logic [DW-1:0] dimg_b,
  input  logic          wren_a,
  input  logic          wren_b,
  output logic [DW-1:0] qreal_a,
  output logic [DW-1:0] qimg_a,
  output logic [DW-1:0] qreal_b,
  output logic [DW-1:0] qimg_b
);
  logic [AW-1:0]   wr_cnt, wr_addr;
  logic            fill_sel, eng_sel, q_sel;
  logic [1:0]      full;
  logic            accept, last, release_bank;
  logic [2*DW-1:0] q_a [2];
  logic [2*DW-1:0] q_b [2];
  assign in_ready     = !rst && !full[fill_sel];
  assign frame_ready  = full[eng_sel];
  assign accept       = in_valid && in_ready;
  assign last         = accept && &wr_cnt;
  assign release_bank = eng_done && frame_ready;
`ifdef CMPLX_BITREV_EN
  logic [31:0] rev;
  assign rev     = bitrev(32'(wr_cnt), AW);
  assign wr_addr = rev[AW-1:0];
`else
  assign wr_addr = wr_cnt;
`endif
  // Port A is taken by the stream only on cycles it writes; otherwise it belongs to the engine.
  for (genvar i = 0; i < 2; i++) begin : g_bank
    logic stream, eng;
    assign stream = accept && fill_sel == 1'(i);
    assign eng    = frame_ready && eng_sel == 1'(i);
    cmplx_bank #(.DW(DW), .AW(AW)) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we_a   (stream || (eng && wren_a)),
      .addr_a (stream ? wr_addr : address_a),
      .d_a    (stream ? {in_real, in_img} : {dreal_a, dimg_a}),
      .q_a    (q_a[i]),
      .we_b   (eng && wren_b),
      .addr_b (address_b),
      .d_b    ({dreal_b, dimg_b}),
      .q_b    (q_b[i])
    );
  end
  // q_sel remembers which bank the engine addressed last cycle, matching the read latency.
  assign {qreal_a, qimg_a} = q_a[q_sel];
  assign {qreal_b, qimg_b} = q_b[q_sel];
  always_ff @(posedge clk)
    if (rst) begin
      wr_cnt   <= '0;
      fill_sel <= 1'b0;
      eng_sel  <= 1'b0;
      q_sel    <= 1'b0;
      full     <= '0;
      overrun  <= 1'b0;
    end else begin
      q_sel   <= eng_sel;
      overrun <= overrun | (in_valid && !in_ready);
      if (accept) wr_cnt <= wr_cnt + 1'b1;
      if (last) begin
        full[fill_sel] <= 1'b1;
        fill_sel       <= !fill_sel;
      end
      if (release_bank) begin
        full[eng_sel] <= 1'b0;
        eng_sel       <= !eng_sel;
      end
    end
endmodule
